// File: rtl/lc3_io_pkg.sv
// Shared constants for the LC-3 memory-mapped keyboard/display controller:
// default register addresses, status-register bit positions and access FSM states.
package lc3_io_pkg;

  localparam logic [15:0] KBSR_ADDR_DEF = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR_DEF = 16'hFE02;
  localparam logic [15:0] DSR_ADDR_DEF  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR_DEF  = 16'hFE06;

  localparam int READY_BIT = 15;
  localparam int IE_BIT    = 14;
  localparam int OVF_BIT   = 0;
  localparam int LEVEL_LSB = 8;
  localparam int LEVEL_MSB = 13;

  typedef enum logic {IDLE, DONE} acc_state_t;

endpackage

// File: rtl/lc3_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on rdata while not empty.
// Extra pointer MSB separates full from empty; a full FIFO accepts a push alongside a pop.
module lc3_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign rdata   = mem[rd_ptr_reg[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/lc3_mmio_fifo_ctrl.sv
// LC-3 keyboard/display MMIO block with RX/TX FIFOs, sticky overflow flags,
// keyboard interrupt and a one-side-effect-per-strobe access handshake.
module lc3_mmio_fifo_ctrl
  import lc3_io_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 16,
  parameter int                CHAR_W    = 8,
  parameter int                RX_DEPTH  = 4,
  parameter int                TX_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] KBSR_ADDR = ADDR_W'(KBSR_ADDR_DEF),
  parameter logic [ADDR_W-1:0] KBDR_ADDR = ADDR_W'(KBDR_ADDR_DEF),
  parameter logic [ADDR_W-1:0] DSR_ADDR  = ADDR_W'(DSR_ADDR_DEF),
  parameter logic [ADDR_W-1:0] DDR_ADDR  = ADDR_W'(DDR_ADDR_DEF)
) (
  input  logic              i_Clk,
  input  logic              reset_,
  input  logic [ADDR_W-1:0] mar,
  input  logic              mio_en,
  input  logic              rw,
  input  logic [DATA_W-1:0] bus,
  output logic              io_hit,
  output logic              r,
  output logic [DATA_W-1:0] io_rdata,
  input  logic              kb_valid,
  input  logic [CHAR_W-1:0] kb_data,
  output logic              kb_ready,
  output logic              disp_valid,
  output logic [CHAR_W-1:0] disp_data,
  input  logic              disp_ready,
  output logic              kb_irq
);

  localparam int RX_LW = $clog2(RX_DEPTH) + 1;
  localparam int TX_LW = $clog2(TX_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ADDR_TAB [4] = '{KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR};

  acc_state_t        state_reg;
  logic              r_reg;
  logic [DATA_W-1:0] io_rdata_reg;
  logic              ie_reg;
  logic              rx_ovf_reg;
  logic              tx_ovf_reg;
  logic [DATA_W-1:0] ddr_hold_reg;
  logic              kb_irq_reg;
  logic              init_done_reg;

  logic [3:0]        hit_vec;
  logic              access;
  logic              rd_acc;
  logic              wr_acc;
  logic [DATA_W-1:0] rdata_next;

  logic              rx_push_req, rx_pop, rx_full, rx_empty, rx_ovf_set;
  logic [CHAR_W-1:0] rx_head;
  logic [RX_LW-1:0]  rx_level;
  logic [31:0]       rx_level_ext;
  logic [5:0]        rx_level_sat;

  logic              tx_push_req, tx_pop, tx_full, tx_empty, tx_ovf_set;
  logic [CHAR_W-1:0] tx_head;
  logic [TX_LW-1:0]  tx_level;
  logic              tx_level_unused;

  // index 0..3 = KBSR, KBDR, DSR, DDR
  for (genvar gi = 0; gi < 4; gi++) begin : g_hit
    assign hit_vec[gi] = (mar == ADDR_TAB[gi]);
  end

  assign io_hit = |hit_vec;
  assign access = (state_reg == IDLE) && mio_en && io_hit;
  assign rd_acc = access && !rw;
  assign wr_acc = access && rw;

  // A full RX FIFO still takes the keyboard character when a KBDR read pops on the same edge.
  assign rx_pop      = rd_acc && hit_vec[1] && !rx_empty;
  assign rx_push_req = kb_valid && init_done_reg;
  assign rx_ovf_set  = rx_push_req && rx_full && !rx_pop;

  assign tx_pop      = disp_ready && !tx_empty;
  assign tx_push_req = wr_acc && hit_vec[3];
  assign tx_ovf_set  = tx_push_req && tx_full && !tx_pop;

  assign rx_level_ext    = 32'(rx_level);
  assign rx_level_sat    = (rx_level_ext > 32'd63) ? 6'd63 : rx_level_ext[5:0];
  assign tx_level_unused = ^tx_level;

  lc3_sync_fifo #(.WIDTH(CHAR_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (i_Clk),
    .rst_n (reset_),
    .push  (rx_push_req),
    .pop   (rx_pop),
    .wdata (kb_data),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  lc3_sync_fifo #(.WIDTH(CHAR_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (i_Clk),
    .rst_n (reset_),
    .push  (tx_push_req),
    .pop   (tx_pop),
    .wdata (bus[CHAR_W-1:0]),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  always_comb begin
    rdata_next = '0;
    if (hit_vec[0]) begin
      rdata_next[READY_BIT]           = !rx_empty;
      rdata_next[IE_BIT]              = ie_reg;
      rdata_next[LEVEL_MSB:LEVEL_LSB] = rx_level_sat;
      rdata_next[OVF_BIT]             = rx_ovf_reg;
    end else if (hit_vec[1]) begin
      rdata_next = rx_empty ? '0 : DATA_W'(rx_head);
    end else if (hit_vec[2]) begin
      rdata_next[READY_BIT] = !tx_full;
      rdata_next[OVF_BIT]   = tx_ovf_reg;
    end else if (hit_vec[3]) begin
      rdata_next = ddr_hold_reg;
    end
  end

  always_ff @(posedge i_Clk or negedge reset_) begin
    if (!reset_) begin
      state_reg     <= IDLE;
      r_reg         <= 1'b0;
      io_rdata_reg  <= '0;
      ie_reg        <= 1'b0;
      rx_ovf_reg    <= 1'b0;
      tx_ovf_reg    <= 1'b0;
      ddr_hold_reg  <= '0;
      kb_irq_reg    <= 1'b0;
      init_done_reg <= 1'b0;
    end else begin
      init_done_reg <= 1'b1;
      kb_irq_reg    <= ie_reg && !rx_empty;

      if (wr_acc && hit_vec[0]) ie_reg <= bus[IE_BIT];

      // A new overflow event wins over a same-edge clear.
      if (rx_ovf_set)                                 rx_ovf_reg <= 1'b1;
      else if (wr_acc && hit_vec[0] && bus[OVF_BIT])  rx_ovf_reg <= 1'b0;

      if (tx_ovf_set)                                 tx_ovf_reg <= 1'b1;
      else if (wr_acc && hit_vec[2] && bus[OVF_BIT])  tx_ovf_reg <= 1'b0;

      if (tx_push_req) ddr_hold_reg <= bus;

      case (state_reg)
        IDLE: begin
          if (mio_en && io_hit) begin
            state_reg    <= DONE;
            r_reg        <= 1'b1;
            io_rdata_reg <= rw ? '0 : rdata_next;
          end
        end
        DONE: begin
          if (!mio_en) begin
            state_reg    <= IDLE;
            r_reg        <= 1'b0;
            io_rdata_reg <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign r          = r_reg;
  assign io_rdata   = io_rdata_reg;
  assign kb_irq     = kb_irq_reg;
  assign kb_ready   = init_done_reg && !rx_full;
  assign disp_valid = !tx_empty;
  assign disp_data  = tx_empty ? '0 : tx_head;

endmodule

// File: tb/tb_lc3_mmio_fifo_ctrl.sv
// Directed bench for lc3_mmio_fifo_ctrl: register access handshake, RX/TX FIFOs,
// overflow flags, interrupt timing and reset mid-access, all with hand-computed values.
module tb_lc3_mmio_fifo_ctrl;

  localparam logic [15:0] KBSR = 16'hFE00;
  localparam logic [15:0] KBDR = 16'hFE02;
  localparam logic [15:0] DSR  = 16'hFE04;
  localparam logic [15:0] DDR  = 16'hFE06;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic [15:0] mar = '0;
  logic        mio_en = 1'b0;
  logic        rw = 1'b0;
  logic [15:0] bus = '0;
  logic        io_hit;
  logic        r;
  logic [15:0] io_rdata;
  logic        kb_valid = 1'b0;
  logic [7:0]  kb_data = '0;
  logic        kb_ready;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        disp_ready = 1'b0;
  logic        kb_irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lc3_mmio_fifo_ctrl dut (
    .i_Clk      (clk),
    .reset_     (reset_),
    .mar        (mar),
    .mio_en     (mio_en),
    .rw         (rw),
    .bus        (bus),
    .io_hit     (io_hit),
    .r          (r),
    .io_rdata   (io_rdata),
    .kb_valid   (kb_valid),
    .kb_data    (kb_data),
    .kb_ready   (kb_ready),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .disp_ready (disp_ready),
    .kb_irq     (kb_irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  // All access tasks start and end on a falling edge.
  task automatic mmio_acc(input logic [15:0] addr, input logic wr, input logic [15:0] wdata,
                          input int hold, output logic [15:0] data, output int lat);
    mar = addr; rw = wr; bus = wdata; mio_en = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!r && lat < 8);
    data = io_rdata;
    repeat (hold) @(negedge clk);
    mio_en = 1'b0;
    @(negedge clk);
    rw = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [15:0] exp,
                        input int hold = 0);
    logic [15:0] d;
    int          lat;
    mmio_acc(addr, 1'b0, 16'h0, hold, d, lat);
    check({tag, "_lat"}, lat, 1);
    check(tag, d, exp);
  endtask

  task automatic wr_reg(input string tag, input logic [15:0] addr, input logic [15:0] wdata);
    logic [15:0] d;
    int          lat;
    mmio_acc(addr, 1'b1, wdata, 0, d, lat);
    check({tag, "_wlat"}, lat, 1);
  endtask

  task automatic kb_push(input logic [7:0] ch);
    kb_valid = 1'b1; kb_data = ch;
    @(negedge clk);
    kb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_r", r, 0);
    check("rst_rdata", io_rdata, 0);
    check("rst_irq", kb_irq, 0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_disp_data", disp_data, 0);
    check("rst_kb_ready", kb_ready, 0);
    reset_ = 1'b1;
    #1 check("kb_ready_pre_edge", kb_ready, 0);
    @(negedge clk);
    check("kb_ready_post_edge", kb_ready, 1);

    // Address decode and non-hit strobe
    mar = DDR;
    #1 check("io_hit_ddr", io_hit, 1);
    mar = 16'hFE01;
    #1 check("io_hit_miss", io_hit, 0);
    mar = 16'h3000; mio_en = 1'b1;
    repeat (3) @(negedge clk);
    check("miss_no_r", r, 0);
    mio_en = 1'b0;
    @(negedge clk);

    rd_chk("kbsr_reset", KBSR, 16'h0000);
    rd_chk("dsr_reset", DSR, 16'h8000);

    // Two characters, long strobe holds, one pop per access
    kb_push(8'h41);
    kb_push(8'h42);
    rd_chk("kbsr_two", KBSR, 16'h8200);
    rd_chk("kbdr_A", KBDR, 16'h0041, 5);
    rd_chk("kbdr_B", KBDR, 16'h0042, 5);
    rd_chk("kbdr_empty", KBDR, 16'h0000);
    rd_chk("kbsr_empty", KBSR, 16'h0000);

    // RX overflow: five characters into a depth-4 FIFO
    for (int i = 0; i < 5; i++) begin
      kb_valid = 1'b1; kb_data = 8'(8'h61 + i);
      @(negedge clk);
      if (i == 2) check("kb_ready_3rd", kb_ready, 1);
      if (i == 3) check("kb_ready_4th", kb_ready, 0);
    end
    kb_valid = 1'b0;
    rd_chk("kbsr_ovf", KBSR, 16'h8401);
    wr_reg("kbsr_w1c", KBSR, 16'h0001);
    rd_chk("kbsr_ovf_clr", KBSR, 16'h8400);

    // Full RX: pop via KBDR and push 0x5A on the same edge
    mar = KBDR; rw = 1'b0; mio_en = 1'b1; kb_valid = 1'b1; kb_data = 8'h5A;
    @(negedge clk);
    kb_valid = 1'b0;
    check("simul_r", r, 1);
    check("simul_data", io_rdata, 16'h0061);
    mio_en = 1'b0;
    @(negedge clk);
    rd_chk("kbsr_simul", KBSR, 16'h8400);
    rd_chk("kbdr_b", KBDR, 16'h0062);
    rd_chk("kbdr_c", KBDR, 16'h0063);
    rd_chk("kbdr_d", KBDR, 16'h0064);
    rd_chk("kbdr_5A", KBDR, 16'h005A);
    rd_chk("kbsr_drained", KBSR, 16'h0000);

    // TX: fill with display stalled, overflow on fifth write, then drain in order
    wr_reg("ddr_30", DDR, 16'h0030);
    check("disp_valid_first", disp_valid, 1);
    check("disp_data_first", disp_data, 8'h30);
    wr_reg("ddr_31", DDR, 16'h0031);
    wr_reg("ddr_32", DDR, 16'h0032);
    wr_reg("ddr_33", DDR, 16'h0033);
    rd_chk("dsr_full", DSR, 16'h0000);
    wr_reg("ddr_34", DDR, 16'h0034);
    rd_chk("dsr_ovf", DSR, 16'h0001);
    rd_chk("ddr_hold", DDR, 16'h0034);
    disp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", disp_valid, 1);
      check("drain_data", disp_data, 8'(8'h30 + i));
      @(negedge clk);
    end
    disp_ready = 1'b0;
    check("tx_empty_valid", disp_valid, 0);
    check("tx_empty_data", disp_data, 0);
    rd_chk("dsr_drained", DSR, 16'h8001);
    wr_reg("dsr_w1c", DSR, 16'h0001);
    rd_chk("dsr_clr", DSR, 16'h8000);

    // Interrupt request lags the FIFO state by one cycle
    wr_reg("kbsr_ie", KBSR, 16'h4000);
    check("irq_idle", kb_irq, 0);
    kb_valid = 1'b1; kb_data = 8'h71;
    @(negedge clk);
    kb_valid = 1'b0;
    check("irq_lag", kb_irq, 0);
    @(negedge clk);
    check("irq_set", kb_irq, 1);
    rd_chk("kbsr_ie_one", KBSR, 16'hC100);
    mar = KBDR; rw = 1'b0; mio_en = 1'b1;
    @(negedge clk);
    check("irq_pop_r", r, 1);
    check("irq_pop_data", io_rdata, 16'h0071);
    check("irq_still", kb_irq, 1);
    mio_en = 1'b0;
    @(negedge clk);
    check("irq_clear", kb_irq, 0);

    // Reset in the middle of an access discards FIFO contents and IE
    kb_push(8'h55);
    mar = KBSR; rw = 1'b0; mio_en = 1'b1;
    @(negedge clk);
    check("mid_r", r, 1);
    reset_ = 1'b0;
    #1;
    check("mid_rst_r", r, 0);
    check("mid_rst_rdata", io_rdata, 0);
    mio_en = 1'b0;
    @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk);
    rd_chk("kbsr_after_rst", KBSR, 16'h0000);
    rd_chk("kbdr_after_rst", KBDR, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
